// File: rtl/wavetable_pkg.sv
// rtl/wavetable_pkg.sv - shared types and defaults for the wavetable write side
package wavetable_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 10;

  // Preloaded table in bank 0 spans indices 0..255.
  localparam logic [ADDR_W_DEF-1:0] RESET_MAX = 10'd255;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FILL      = 2'd1,
    PEND_SWAP = 2'd2
  } wr_state_t;

endpackage

// File: rtl/wavetable_writer.sv
// rtl/wavetable_writer.sv - loads one waveform period into the idle bank of a ping-pong wave RAM
module wavetable_writer
  import wavetable_pkg::*;
#(
  parameter int                DATA_W    = DATA_W_DEF,
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter int                MIN_LEN   = 2,
  parameter logic [ADDR_W-1:0] RESET_MAX = wavetable_pkg::RESET_MAX
) (
  input  logic              sample_adjust_clk,
  input  logic              Reset,
  input  logic              load_start,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  input  logic [ADDR_W-1:0] addr_counter,
  output logic              ram_we,
  output logic [ADDR_W:0]   ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              rd_bank,
  output logic [ADDR_W-1:0] max_count,
  output logic              busy,
  output logic              load_err
);

  // Index of the last sample of the shortest acceptable period.
  localparam logic [ADDR_W-1:0] MIN_IDX = ADDR_W'(MIN_LEN - 1);

  wr_state_t         state, state_nx;
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] pend_max;

  logic accept;
  logic wptr_full;
  logic clr_ptr;
  logic do_wr;
  logic set_err;
  logic take_pend;
  logic do_swap;

  assign accept    = wr_valid && (state == FILL);
  assign wptr_full = (wptr == {ADDR_W{1'b1}});
  assign busy      = (state != IDLE);

  // State register.
  always_ff @(posedge sample_adjust_clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state decode and per-cycle control strobes for the datapath.
  always_comb begin
    state_nx  = state;
    wr_ready  = 1'b0;
    clr_ptr   = 1'b0;
    do_wr     = 1'b0;
    set_err   = 1'b0;
    take_pend = 1'b0;
    do_swap   = 1'b0;
    case (state)
      IDLE: begin
        if (load_start) begin
          clr_ptr  = 1'b1;
          state_nx = FILL;
        end
      end
      FILL: begin
        wr_ready = 1'b1;
        if (load_start) begin
          // Restart: the sample offered alongside the restart is dropped.
          clr_ptr = 1'b1;
        end else if (accept) begin
          do_wr = 1'b1;
          if (wr_last || wptr_full) begin
            if (wptr < MIN_IDX) begin
              set_err  = 1'b1;
              state_nx = IDLE;
            end else begin
              take_pend = 1'b1;
              set_err   = !wr_last;
              state_nx  = PEND_SWAP;
            end
          end
        end
      end
      PEND_SWAP: begin
        if (load_start) begin
          clr_ptr  = 1'b1;
          state_nx = FILL;
        end else if ((addr_counter == '0) && !ram_we) begin
          // Swap only at the reader's period boundary, after the last write landed.
          do_swap  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Write pointer, registered RAM write port, error flag and bank handover.
  always_ff @(posedge sample_adjust_clk) begin
    if (Reset) begin
      wptr      <= '0;
      pend_max  <= '0;
      rd_bank   <= 1'b0;
      max_count <= RESET_MAX;
      ram_we    <= 1'b0;
      ram_waddr <= '0;
      ram_wdata <= '0;
      load_err  <= 1'b0;
    end else begin
      ram_we <= do_wr;
      if (do_wr) begin
        ram_waddr <= {~rd_bank, wptr};
        ram_wdata <= wr_data;
      end
      if (clr_ptr) begin
        wptr     <= '0;
        load_err <= 1'b0;
      end else begin
        if (do_wr && !wptr_full) wptr <= wptr + 1'b1;
        if (set_err)             load_err <= 1'b1;
      end
      if (take_pend) pend_max <= wptr;
      if (do_swap) begin
        rd_bank   <= ~rd_bank;
        max_count <= pend_max;
      end
    end
  end

endmodule
